// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: read-side client of the 1-bit frame buffer.
// Walks the buffer with an incrementing pixel counter driven by de/vs and
// delays hs/vs/de to line up with the buffer's read latency. Expands each
// 1-bit pixel to 24-bit RGB and flags frames with a wrong active pixel count.
module frame_buffer_reader #(
    parameter int          HOR_ACTIVE_PIXELS = 640,
    parameter int          VER_ACTIVE_PIXELS = 480,
    parameter logic        HOR_SYNC_POLARITY = 1'b0,
    parameter logic        VER_SYNC_POLARITY = 1'b0,
    parameter int          RD_LATENCY        = 1,
    parameter logic [23:0] FG_COLOR          = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR          = 24'h000000,
    localparam int         TOTAL             = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
    localparam int         PIXEL_ADDR_WIDTH  = $clog2(TOTAL)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ce,
    input  logic                        hs_in,
    input  logic                        vs_in,
    input  logic                        de_in,
    output logic [PIXEL_ADDR_WIDTH-1:0] rd_addr,
    input  logic                        rd_data,
    output logic                        hs,
    output logic                        vs,
    output logic                        de,
    output logic [7:0]                  r,
    output logic [7:0]                  g,
    output logic [7:0]                  b,
    output logic                        frame_error
);

    localparam logic [PIXEL_ADDR_WIDTH-1:0] LAST_ADDR = PIXEL_ADDR_WIDTH'(TOTAL - 1);

    logic                        vs_prev;
    logic                        fs;
    logic                        last_addr;
    logic                        armed;
    logic                        wrapped;
    logic [PIXEL_ADDR_WIDTH-1:0] addr_nxt;
    logic                        armed_nxt;
    logic                        wrapped_nxt;
    logic                        error_nxt;

    logic [RD_LATENCY-1:0]       hs_pipe;
    logic [RD_LATENCY-1:0]       vs_pipe;
    logic [RD_LATENCY-1:0]       de_pipe;

    // A frame starts on the first cycle vs_in enters its active level.
    assign fs        = (vs_in == VER_SYNC_POLARITY) && (vs_prev != VER_SYNC_POLARITY);
    assign last_addr = (rd_addr == LAST_ADDR);

    // Next counter, wrap/arm flags and error flag; frame start wins over increment.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        addr_nxt    = rd_addr;
        armed_nxt   = armed;
        wrapped_nxt = wrapped;
        error_nxt   = frame_error;
        if (fs) begin
            // Previous frame is good only if the counter wrapped exactly once back to 0.
            if (armed && !(rd_addr == '0 && wrapped)) begin
                error_nxt = 1'b1;
            end
            addr_nxt    = de_in ? PIXEL_ADDR_WIDTH'(1) : '0;
            wrapped_nxt = de_in && last_addr;
            armed_nxt   = 1'b1;
        end else if (de_in) begin
            if (last_addr) begin
                addr_nxt    = '0;
                wrapped_nxt = 1'b1;
                if (wrapped) begin
                    error_nxt = 1'b1;
                end
            end else begin
                addr_nxt = rd_addr + PIXEL_ADDR_WIDTH'(1);
            end
        end
    end

    // Counter, frame-check state and previous vsync register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
            rd_addr     <= '0;
            armed       <= 1'b0;
            wrapped     <= 1'b0;
            frame_error <= 1'b0;
            vs_prev     <= ~VER_SYNC_POLARITY;
        end else if (ce) begin
            rd_addr     <= addr_nxt;
            armed       <= armed_nxt;
            wrapped     <= wrapped_nxt;
            frame_error <= error_nxt;
            vs_prev     <= vs_in;
        end
    end

    // Sync delay line covering the buffer read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this small delay line is reset to inactive sync levels so no false sync/de leaks out after reset.
            hs_pipe <= {RD_LATENCY{~HOR_SYNC_POLARITY}};
            vs_pipe <= {RD_LATENCY{~VER_SYNC_POLARITY}};
            de_pipe <= '0;
        end else if (ce) begin
            hs_pipe[0] <= hs_in;
            vs_pipe[0] <= vs_in;
            de_pipe[0] <= de_in;
            for (int i = 1; i < RD_LATENCY; i++) begin
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
                de_pipe[i] <= de_pipe[i-1];
            end
        end
    end

    // Output stage: registered syncs and colour expansion, blanked outside de.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs        <= ~HOR_SYNC_POLARITY;
            vs        <= ~VER_SYNC_POLARITY;
            de        <= 1'b0;
            {r, g, b} <= '0;
        end else if (ce) begin
            hs <= hs_pipe[RD_LATENCY-1];
            vs <= vs_pipe[RD_LATENCY-1];
            de <= de_pipe[RD_LATENCY-1];
            if (de_pipe[RD_LATENCY-1]) begin
                {r, g, b} <= rd_data ? FG_COLOR : BG_COLOR;
            end else begin
                {r, g, b} <= '0;
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Bench for frame_buffer_reader: a 4x3 frame with checkerboard buffer contents,
// two instances (read latency 1 and 3) driven by the same pixel timing.
module tb_frame_buffer_reader;

    localparam int H     = 4;
    localparam int V     = 3;
    localparam int TOTAL = H * V;

    typedef struct {
        logic hs;
        logic vs;
        logic de;
        int   addr;
    } hist_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ce, hs_in, vs_in, de_in;

    logic [3:0] rd_addr1, rd_addr3;
    logic       rd_data1, rd_data3;
    logic       hs1, vs1, de1, fe1, hs3, vs3, de3, fe3;
    logic [7:0] r1, g1, b1, r3, g3, b3;

    logic [3:0] a1 = '0;
    logic [3:0] a3 [3] = '{default: '0};

    hist_t hist [4];
    int    idx;
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;

    frame_buffer_reader #(
        .HOR_ACTIVE_PIXELS(H), .VER_ACTIVE_PIXELS(V), .RD_LATENCY(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .ce(ce), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .hs(hs1), .vs(vs1), .de(de1),
        .r(r1), .g(g1), .b(b1), .frame_error(fe1)
    );

    frame_buffer_reader #(
        .HOR_ACTIVE_PIXELS(H), .VER_ACTIVE_PIXELS(V), .RD_LATENCY(3)
    ) u_dut3 (
        .clk(clk), .rst(rst), .ce(ce), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .rd_addr(rd_addr3), .rd_data(rd_data3), .hs(hs3), .vs(vs3), .de(de3),
        .r(r3), .g(g3), .b(b3), .frame_error(fe3)
    );

    // Checkerboard buffer contents: pixel = (x ^ y) & 1.
    function automatic logic pix(input int addr);
        int x, y;
        x = addr % H;
        y = addr / H;
        return 1'((x ^ y) & 1);
    endfunction

    // Buffer model with 1 and 3 cycles of read latency, advancing on ce.
    always @(posedge clk) begin
        if (ce) begin
            a1    <= rd_addr1;
            a3[0] <= rd_addr3;
            a3[1] <= a3[0];
            a3[2] <= a3[1];
        end
    end
    assign rd_data1 = pix(int'(a1));
    assign rd_data3 = pix(int'(a3[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [23:0] exp_rgb(input hist_t e);
        if (!e.de) return 24'h000000;
        return pix(e.addr) ? 24'hFFFFFF : 24'h000000;
    endfunction

    task automatic reset_hist();
        for (int i = 0; i < 4; i++) hist[i] = '{1'b1, 1'b1, 1'b0, 0};
    endtask

    task automatic check_out();
        check("d1_hs",  {31'd0, hs1}, {31'd0, hist[1].hs});
        check("d1_vs",  {31'd0, vs1}, {31'd0, hist[1].vs});
        check("d1_de",  {31'd0, de1}, {31'd0, hist[1].de});
        check("d1_rgb", {8'd0, r1, g1, b1}, {8'd0, exp_rgb(hist[1])});
        check("d3_hs",  {31'd0, hs3}, {31'd0, hist[3].hs});
        check("d3_vs",  {31'd0, vs3}, {31'd0, hist[3].vs});
        check("d3_de",  {31'd0, de3}, {31'd0, hist[3].de});
        check("d3_rgb", {8'd0, r3, g3, b3}, {8'd0, exp_rgb(hist[3])});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr1"}, 32'(rd_addr1), 32'd0);
        check({tag, "_addr3"}, 32'(rd_addr3), 32'd0);
        check({tag, "_hs1"},   32'(hs1), 32'd1);
        check({tag, "_vs1"},   32'(vs1), 32'd1);
        check({tag, "_de1"},   32'(de1), 32'd0);
        check({tag, "_rgb1"},  {8'd0, r1, g1, b1}, 32'd0);
        check({tag, "_de3"},   32'(de3), 32'd0);
        check({tag, "_fe1"},   32'(fe1), 32'd0);
        check({tag, "_fe3"},   32'(fe3), 32'd0);
    endtask

    // One pixel-clock cycle of input; entered and left at posedge+1.
    task automatic cyc(input logic h, input logic v, input logic d);
        hs_in = h;
        vs_in = v;
        de_in = d;
        if (d) begin
            check("d1_addr", 32'(rd_addr1), 32'(idx % TOTAL));
            check("d3_addr", 32'(rd_addr3), 32'(idx % TOTAL));
        end
        @(posedge clk);
        if (ce) begin
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = '{h, v, d, idx % TOTAL};
            if (d) idx++;
        end
        #1;
        check_out();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        hs_in = 1'b1;
        vs_in = 1'b1;
        de_in = 1'b0;
        #1;
        check_reset_values("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_hist();
        idx = 0;
    endtask

    // Asynchronous reset in the middle of a cycle, checked before the next edge.
    task automatic mid_reset();
        check("pre_rst_addr", 32'(rd_addr1), 32'd5);
        #2;
        do_reset();
    endtask

    // Vsync pulse, back porch, then n_slots active slots in lines of H.
    task automatic frame(input int n_slots, input int drop_slot, input int gap_slot, input int rst_slot);
        idx = 0;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        for (int s = 0; s < n_slots; s++) begin
            if (s == rst_slot) begin
                mid_reset();
                return;
            end
            if (s == gap_slot) begin
                ce = 1'b0;
                repeat (10) cyc(1'b1, 1'b1, 1'b1);
                ce = 1'b1;
            end
            cyc(1'b1, 1'b1, s != drop_slot);
            if ((s % H == H - 1) || (s == n_slots - 1)) begin
                cyc(1'b0, 1'b1, 1'b0);
                cyc(1'b1, 1'b1, 1'b0);
            end
        end
    endtask

    task automatic check_fe(input string tag, input logic exp);
        check({tag, "_1"}, 32'(fe1), 32'(exp));
        check({tag, "_3"}, 32'(fe3), 32'(exp));
    endtask

    initial begin
        ce    = 1'b1;
        hs_in = 1'b1;
        vs_in = 1'b1;
        de_in = 1'b0;
        reset_hist();
        idx = 0;
        #1;
        do_reset();

        // Three clean frames: first fs only arms, later ones pass.
        frame(TOTAL, -1, -1, -1);
        check_fe("fe_f1", 1'b0);
        frame(TOTAL, -1, -1, -1);
        frame(TOTAL, -1, -1, -1);
        check_fe("fe_f3", 1'b0);
        check("wrap_to_0", 32'(rd_addr1), 32'd0);

        // Clock enable low for 10 cycles mid-line.
        frame(TOTAL, -1, 2, -1);
        check_fe("fe_gap", 1'b0);

        // Dropped de pulse: flagged at the following fs, then sticky.
        frame(TOTAL, 7, -1, -1);
        check_fe("fe_pre_drop_fs", 1'b0);
        check("short_addr", 32'(rd_addr1), 32'd11);
        frame(TOTAL, -1, -1, -1);
        check_fe("fe_drop", 1'b1);
        frame(TOTAL, -1, -1, -1);
        check_fe("fe_sticky", 1'b1);

        // Reset mid-frame at rd_addr=5; next fs re-arms, following frame passes.
        frame(TOTAL, -1, -1, 5);
        check_fe("fe_after_rst", 1'b0);
        frame(TOTAL, -1, -1, -1);
        check_fe("fe_rearm", 1'b0);
        frame(TOTAL, -1, -1, -1);
        check_fe("fe_clean", 1'b0);

        // One extra de pulse: counter wraps to 0 then 1, flagged at next fs.
        frame(TOTAL + 1, -1, -1, -1);
        check("extra_addr", 32'(rd_addr1), 32'd1);
        check_fe("fe_pre_extra_fs", 1'b0);
        frame(0, -1, -1, -1);
        check_fe("fe_extra", 1'b1);

        // Two wraps in one frame: flagged on the second wrap itself.
        @(posedge clk);
        #1;
        do_reset();
        idx = 0;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        repeat (2 * TOTAL - 1) cyc(1'b1, 1'b1, 1'b1);
        check_fe("fe_pre_wrap2", 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        check_fe("fe_wrap2", 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
